baud_gen_frac: RTL

- Parametrised successor to the fixed baud generator: one fractional-N base divider produces single-cycle clock-enable ticks instead of derived clocks.
- RX_Tick is the oversample-rate tick; TX_Tick is the bit-rate tick (one per OVERSAMPLE RX_Ticks); RX_Mid is a bit-centre sample strobe that the receiver can realign.
- Divisor is runtime-programmable through a shadow register that is applied only on a bit boundary.
- Sits between the system clock and the UART TX/RX engines.

---
 rtl/baud_gen_frac.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator: one base divider yields oversample, bit and
// bit-centre clock-enable strobes, with a shadowed divisor applied on bit boundaries.
module baud_gen_frac #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DEF_INT    = 27,
  parameter int DEF_FRAC   = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [DIV_W-1:0]  Div_Int,
  input  logic [FRAC_W-1:0] Div_Frac,
  input  logic              Div_Load,
  output logic              Div_Pending,
  input  logic              Rx_Resync,
  output logic              RX_Tick,
  output logic              TX_Tick,
  output logic              RX_Mid
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W-1:0]  DIV_MIN  = DIV_W'(2);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DEF_I    = DIV_W'(DEF_INT);
  localparam logic [FRAC_W-1:0] DEF_F    = FRAC_W'(DEF_FRAC);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    if (v < DIV_MIN) begin
      return DIV_MIN;
    end else begin
      return v;
    end
  endfunction

  logic [DIV_W-1:0]  act_int_r, act_int_s, sh_int_r, sh_int_s, cnt_r, cnt_s;
  logic [FRAC_W-1:0] act_frac_r, act_frac_s, sh_frac_r, sh_frac_s, acc_r, acc_s;
  logic [FRAC_W:0]   sum_s;
  logic [OS_W-1:0]   tx_os_r, tx_os_s, rx_os_r, rx_os_s;
  logic              pend_r, pend_s;
  logic              rx_tick_r, tx_tick_r, rx_mid_r;
  logic              rx_tick_s, tx_tick_s, rx_mid_s;
  logic              zero_s, tx_wrap_s, apply_s;

  // Next-state logic: divider reload, fractional carry, os counters, divisor shadow
  always_comb begin
    zero_s     = Enable && (cnt_r == {DIV_W{1'b0}});
    tx_wrap_s  = zero_s && (tx_os_r == OS_LAST);
    // while disabled nothing is counting, so a pending divisor can land at once
    apply_s    = pend_r && (tx_wrap_s || !Enable);
    sum_s      = {1'b0, acc_r} + {1'b0, act_frac_r};
    cnt_s      = cnt_r;
    acc_s      = acc_r;
    act_int_s  = act_int_r;
    act_frac_s = act_frac_r;
    sh_int_s   = sh_int_r;
    sh_frac_s  = sh_frac_r;
    pend_s     = pend_r;
    tx_os_s    = tx_os_r;
    rx_os_s    = rx_os_r;
    rx_tick_s  = zero_s;
    tx_tick_s  = tx_wrap_s;
    rx_mid_s   = zero_s && !Rx_Resync && (rx_os_r == OS_MID);

    if (zero_s) begin
      if (apply_s) begin
        cnt_s = sh_int_r - DIV_ONE;
        acc_s = {FRAC_W{1'b0}};
      end else begin
        acc_s = sum_s[FRAC_W-1:0];
        cnt_s = sum_s[FRAC_W] ? act_int_r : (act_int_r - DIV_ONE);
      end
      tx_os_s = tx_wrap_s ? {OS_W{1'b0}} : (tx_os_r + OS_W'(1));
    end else if (Enable) begin
      cnt_s = cnt_r - DIV_ONE;
    end else begin
      cnt_s = cnt_r;
      if (apply_s) begin
        acc_s = {FRAC_W{1'b0}};
      end else begin
        acc_s = acc_r;
      end
    end

    if (Rx_Resync) begin
      rx_os_s = {OS_W{1'b0}};
    end else if (zero_s) begin
      rx_os_s = rx_os_r + OS_W'(1);
    end else begin
      rx_os_s = rx_os_r;
    end

    if (apply_s) begin
      act_int_s  = sh_int_r;
      act_frac_s = sh_frac_r;
    end else begin
      act_int_s  = act_int_r;
      act_frac_s = act_frac_r;
    end

    // a load coinciding with application is kept pending
    if (Div_Load) begin
      sh_int_s  = clamp_div(Div_Int);
      sh_frac_s = Div_Frac;
      pend_s    = 1'b1;
    end else if (apply_s) begin
      pend_s = 1'b0;
    end else begin
      pend_s = pend_r;
    end
  end

  // State and output registers with synchronous reset to the default divisor
  always_ff @(posedge Clock) begin
    if (Reset) begin
      act_int_r  <= DEF_I;
      act_frac_r <= DEF_F;
      sh_int_r   <= {DIV_W{1'b0}};
      sh_frac_r  <= {FRAC_W{1'b0}};
      pend_r     <= 1'b0;
      cnt_r      <= DEF_I - DIV_ONE;
      acc_r      <= {FRAC_W{1'b0}};
      tx_os_r    <= {OS_W{1'b0}};
      rx_os_r    <= {OS_W{1'b0}};
      rx_tick_r  <= 1'b0;
      tx_tick_r  <= 1'b0;
      rx_mid_r   <= 1'b0;
    end else begin
      act_int_r  <= act_int_s;
      act_frac_r <= act_frac_s;
      sh_int_r   <= sh_int_s;
      sh_frac_r  <= sh_frac_s;
      pend_r     <= pend_s;
      cnt_r      <= cnt_s;
      acc_r      <= acc_s;
      tx_os_r    <= tx_os_s;
      rx_os_r    <= rx_os_s;
      rx_tick_r  <= rx_tick_s;
      tx_tick_r  <= tx_tick_s;
      rx_mid_r   <= rx_mid_s;
    end
  end

  assign RX_Tick     = rx_tick_r;
  assign TX_Tick     = tx_tick_r;
  assign RX_Mid      = rx_mid_r;
  assign Div_Pending = pend_r;

endmodule
